// File: rtl/contador_ctrl.sv
// -----------------------------------------------------------------------------
// contador_ctrl
//
// Sequencing controller for the negedge-clocked ripple counter `contador`.
// The controller runs on the posedge of clk. The counter shares the same clock
// net, advances on the negedge, and is driven through cnt_en / cnt_clr_n.
//
// Features: start/stop/pause control, a terminal count latched at run start,
// one-shot or periodic (auto-clear) operation, a done pulse for every terminal
// count, and a saturating tally of periodic wraps.
//
// Ports:
//   clk        in   system clock (controller posedge, counter negedge)
//   clr_n      in   asynchronous active-low reset
//   start      in   level: begin a run from IDLE, resume from HOLD
//   stop       in   level: pause from RUN, abort from HOLD or CLEAR
//   mode       in   0 = one-shot, 1 = periodic (latched at run start)
//   limit      in   terminal count [Size] (latched at run start)
//   cnt_q      in   counter readback [Size], settled by each posedge
//   cnt_en     out  counter enable (registered)
//   cnt_clr_n  out  counter asynchronous clear, active-low (registered)
//   busy       out  high in CLEAR, RUN and HOLD
//   done       out  one-cycle pulse after cnt_q reached the latched limit
//   err        out  one-cycle pulse after a start request with limit == 0
//   wraps      out  periodic terminal-count tally [WrapW], saturating
//   dbg_state  out  current FSM state (0 IDLE, 1 CLEAR, 2 RUN, 3 HOLD)
//
// Control protocol: start and stop are levels sampled at every posedge, with
// no handshake. A request takes effect at the posedge where it is seen high.
// The command is consumed at that edge, so the requester should drop the level
// afterwards. Otherwise the request repeats on later edges (for example, start
// held high in IDLE with limit == 0 pulses err on every cycle).
// -----------------------------------------------------------------------------
module contador_ctrl #(
  parameter int Size  = 8,
  parameter int WrapW = 8
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [Size-1:0]  limit,
  input  logic [Size-1:0]  cnt_q,
  output logic             cnt_en,
  output logic             cnt_clr_n,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WrapW-1:0] wraps,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    HOLD  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [Size-1:0]  limit_r_q, limit_r_d;
  logic             mode_r_q, mode_r_d;
  logic [WrapW-1:0] wraps_q, wraps_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             cnt_en_q, cnt_en_d;
  logic             cnt_clr_n_q, cnt_clr_n_d;
  logic             match;

  // A terminal count only counts while running. In CLEAR and HOLD the counter
  // may legitimately show the old limit value.
  assign match = (state_q == RUN) && (cnt_q == limit_r_q);

  always_comb begin
    state_d   = state_q;
    limit_r_d = limit_r_q;
    mode_r_d  = mode_r_q;
    wraps_d   = wraps_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (limit != '0) begin
            state_d   = CLEAR;
            limit_r_d = limit;
            mode_r_d  = mode;
            wraps_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      CLEAR: begin
        state_d = stop ? IDLE : RUN;
      end

      RUN: begin
        // A match takes priority over stop, and stop over start (start is
        // ignored here).
        if (match) begin
          done_d = 1'b1;
          if (mode_r_q) begin
            state_d = CLEAR;
            if (wraps_q != '1) begin
              wraps_d = wraps_q + 1'b1;
            end
          end else begin
            state_d = IDLE;
          end
        end else if (stop) begin
          state_d = HOLD;
        end
      end

      HOLD: begin
        if (stop) begin
          state_d = IDLE;
        end else if (start) begin
          state_d = RUN;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Counter controls are decoded from the next state. That way cnt_en drops
    // at the matching posedge, before the negedge that would step past the
    // limit.
    cnt_en_d    = (state_d == RUN);
    cnt_clr_n_d = (state_d != CLEAR);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= IDLE;
      limit_r_q   <= '0;
      mode_r_q    <= 1'b0;
      wraps_q     <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cnt_en_q    <= 1'b0;
      // Hold the counter in clear for as long as reset is asserted.
      cnt_clr_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      limit_r_q   <= limit_r_d;
      mode_r_q    <= mode_r_d;
      wraps_q     <= wraps_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cnt_en_q    <= cnt_en_d;
      cnt_clr_n_q <= cnt_clr_n_d;
    end
  end

  assign cnt_en    = cnt_en_q;
  assign cnt_clr_n = cnt_clr_n_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign wraps     = wraps_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_contador_ctrl.sv
module tb_contador_ctrl;

  localparam int SIZE = 8;

  // ---------------- clock / reset / stimulus ----------------
  logic clk = 1'b0;
  logic clr_n = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic mode = 1'b0;
  logic [SIZE-1:0] limit = '0;

  always #5 clk = ~clk;

  // DUT with the default tally width
  logic [SIZE-1:0] cnt_q;
  logic cnt_en, cnt_clr_n, busy, done, err;
  logic [7:0] wraps;
  logic [1:0] dbg_state;

  contador_ctrl #(.Size(SIZE), .WrapW(8)) dut (
    .clk(clk), .clr_n(clr_n), .start(start), .stop(stop), .mode(mode),
    .limit(limit), .cnt_q(cnt_q), .cnt_en(cnt_en), .cnt_clr_n(cnt_clr_n),
    .busy(busy), .done(done), .err(err), .wraps(wraps), .dbg_state(dbg_state)
  );

  // Second DUT with a 2-bit tally, used to check saturation
  logic [SIZE-1:0] cnt2_q;
  logic cnt2_en, cnt2_clr_n, busy2, done2, err2;
  logic [1:0] wraps2;
  logic [1:0] dbg_state2;

  contador_ctrl #(.Size(SIZE), .WrapW(2)) dut_w2 (
    .clk(clk), .clr_n(clr_n), .start(start), .stop(stop), .mode(mode),
    .limit(limit), .cnt_q(cnt2_q), .cnt_en(cnt2_en), .cnt_clr_n(cnt2_clr_n),
    .busy(busy2), .done(done2), .err(err2), .wraps(wraps2), .dbg_state(dbg_state2)
  );

  // Behavioural ripple counters: negedge clocked, asynchronous clear
  always @(negedge clk or negedge cnt_clr_n)
    if (!cnt_clr_n) cnt_q <= '0;
    else if (cnt_en) cnt_q <= cnt_q + 1'b1;

  always @(negedge clk or negedge cnt2_clr_n)
    if (!cnt2_clr_n) cnt2_q <= '0;
    else if (cnt2_en) cnt2_q <= cnt2_q + 1'b1;

  // Counter value as the controller samples it at each posedge
  logic [SIZE-1:0] cnt_edge;
  always @(posedge clk) cnt_edge <= cnt_q;

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_err = 0;

  localparam logic [1:0] S_IDLE = 2'd0, S_CLEAR = 2'd1, S_RUN = 2'd2, S_HOLD = 2'd3;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver / check tasks ----------------
  task automatic test_reset();
    #3;
    n_cmp++; if (cnt_clr_n !== 1'b0) begin n_err++; $display("FAIL reset_clr_n got %b want 0", cnt_clr_n); end
    n_cmp++; if (cnt_en !== 1'b0) begin n_err++; $display("FAIL reset_en got %b want 0", cnt_en); end
    n_cmp++; if ({busy, done, err} !== 3'b000) begin n_err++; $display("FAIL reset_flags got %b want 000", {busy, done, err}); end
    n_cmp++; if (wraps !== 8'd0) begin n_err++; $display("FAIL reset_wraps got %0d want 0", wraps); end
    n_cmp++; if (cnt_q !== 8'd0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", cnt_q); end
    n_cmp++; if (dbg_state !== S_IDLE) begin n_err++; $display("FAIL reset_state got %0d want 0", dbg_state); end
    step();
    clr_n = 1'b1;
    step();
    n_cmp++; if (cnt_clr_n !== 1'b1) begin n_err++; $display("FAIL release_clr_n got %b want 1", cnt_clr_n); end
    n_cmp++; if ({busy, cnt_en} !== 2'b00) begin n_err++; $display("FAIL release_idle got %b want 00", {busy, cnt_en}); end
  endtask

  task automatic test_one_shot();
    mode = 1'b0; limit = 8'd5; start = 1'b1;
    step();  // T0
    start = 1'b0;
    n_cmp++; if ({cnt_clr_n, cnt_en, busy} !== 3'b001) begin n_err++; $display("FAIL os_t0 got %b want 001", {cnt_clr_n, cnt_en, busy}); end
    n_cmp++; if (dbg_state !== S_CLEAR) begin n_err++; $display("FAIL os_t0_state got %0d want 1", dbg_state); end
    for (int k = 1; k <= 6; k++) begin
      step();
      n_cmp++; if (done !== (k == 6)) begin n_err++; $display("FAIL os_done k=%0d got %b want %b", k, done, (k == 6)); end
      n_cmp++; if (cnt_edge !== 8'(k - 1)) begin n_err++; $display("FAIL os_cnt k=%0d got %0d want %0d", k, cnt_edge, k - 1); end
      n_cmp++; if (busy !== (k < 6)) begin n_err++; $display("FAIL os_busy k=%0d got %b want %b", k, busy, (k < 6)); end
      n_cmp++; if (cnt_en !== (k < 6)) begin n_err++; $display("FAIL os_en k=%0d got %b want %b", k, cnt_en, (k < 6)); end
    end
    step(); step();
    n_cmp++; if (cnt_q !== 8'd5) begin n_err++; $display("FAIL os_hold_cnt got %0d want 5", cnt_q); end
    n_cmp++; if ({done, busy, cnt_en, cnt_clr_n} !== 4'b0001) begin n_err++; $display("FAIL os_after got %b want 0001", {done, busy, cnt_en, cnt_clr_n}); end
  endtask

  task automatic test_periodic();
    mode = 1'b1; limit = 8'd3; start = 1'b1;
    step();  // T0
    start = 1'b0;
    // Changes to mode/limit while running must not matter.
    mode = 1'b0; limit = 8'd7;
    for (int k = 1; k <= 16; k++) begin
      start = (k == 6);  // sampled in RUN, must be ignored
      step();
      n_cmp++; if (done !== (k % 4 == 0)) begin n_err++; $display("FAIL per_done k=%0d got %b want %b", k, done, (k % 4 == 0)); end
      n_cmp++; if (cnt_edge !== 8'((k - 1) % 4)) begin n_err++; $display("FAIL per_cnt k=%0d got %0d want %0d", k, cnt_edge, (k - 1) % 4); end
      if (k % 4 == 0) begin
        n_cmp++; if (wraps !== 8'(k / 4)) begin n_err++; $display("FAIL per_wraps k=%0d got %0d want %0d", k, wraps, k / 4); end
      end
    end
    start = 1'b0;
    n_cmp++; if (wraps2 !== 2'd3) begin n_err++; $display("FAIL per_wraps_sat got %0d want 3", wraps2); end
    n_cmp++; if (dbg_state !== S_CLEAR) begin n_err++; $display("FAIL per_clear_state got %0d want 1", dbg_state); end
    // Abort from CLEAR
    stop = 1'b1;
    step();
    stop = 1'b0;
    n_cmp++; if ({busy, cnt_en, cnt_clr_n} !== 3'b001) begin n_err++; $display("FAIL per_abort got %b want 001", {busy, cnt_en, cnt_clr_n}); end
    n_cmp++; if (wraps !== 8'd4) begin n_err++; $display("FAIL per_wraps_keep got %0d want 4", wraps); end
    step();
  endtask

  task automatic test_hold_resume();
    mode = 1'b0; limit = 8'd10; start = 1'b1;
    step();  // T0
    start = 1'b0;
    n_cmp++; if (wraps !== 8'd0) begin n_err++; $display("FAIL hold_wraps_zero got %0d want 0", wraps); end
    for (int k = 1; k <= 4; k++) step();
    stop = 1'b1;
    step();  // T5: pause with cnt_q == 4
    stop = 1'b0;
    n_cmp++; if (cnt_edge !== 8'd4) begin n_err++; $display("FAIL hold_edge got %0d want 4", cnt_edge); end
    n_cmp++; if ({cnt_en, busy} !== 2'b01) begin n_err++; $display("FAIL hold_t5 got %b want 01", {cnt_en, busy}); end
    n_cmp++; if (dbg_state !== S_HOLD) begin n_err++; $display("FAIL hold_state got %0d want 3", dbg_state); end
    step(); step();  // T6, T7
    n_cmp++; if (cnt_q !== 8'd4) begin n_err++; $display("FAIL hold_frozen got %0d want 4", cnt_q); end
    n_cmp++; if (cnt_en !== 1'b0) begin n_err++; $display("FAIL hold_en got %b want 0", cnt_en); end
    start = 1'b1;
    step();  // T8: resume
    start = 1'b0;
    n_cmp++; if (cnt_en !== 1'b1) begin n_err++; $display("FAIL resume_en got %b want 1", cnt_en); end
    for (int k = 9; k <= 15; k++) begin
      step();
      n_cmp++; if (done !== (k == 14)) begin n_err++; $display("FAIL resume_done k=%0d got %b want %b", k, done, (k == 14)); end
    end
    n_cmp++; if (cnt_q !== 8'd10) begin n_err++; $display("FAIL resume_final got %0d want 10", cnt_q); end
  endtask

  task automatic test_err();
    limit = 8'd0; mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++; if ({err, busy, cnt_en} !== 3'b100) begin n_err++; $display("FAIL err_pulse got %b want 100", {err, busy, cnt_en}); end
    step();
    n_cmp++; if ({err, busy, cnt_en} !== 3'b000) begin n_err++; $display("FAIL err_after got %b want 000", {err, busy, cnt_en}); end
  endtask

  task automatic test_stop_at_match();
    limit = 8'd2; mode = 1'b0; start = 1'b1;
    step();  // T0
    start = 1'b0;
    step(); step();  // T1, T2
    stop = 1'b1;
    step();  // T3: match and stop together
    stop = 1'b0;
    n_cmp++; if ({done, busy} !== 2'b10) begin n_err++; $display("FAIL stopm_t3 got %b want 10", {done, busy}); end
    n_cmp++; if (cnt_edge !== 8'd2) begin n_err++; $display("FAIL stopm_cnt got %0d want 2", cnt_edge); end
    step();
    n_cmp++; if ({done, busy, dbg_state} !== 4'b0000) begin n_err++; $display("FAIL stopm_t4 got %b want 0000", {done, busy, dbg_state}); end
  endtask

  task automatic test_reset_mid_run();
    limit = 8'd10; mode = 1'b0; start = 1'b1;
    step();  // T0
    start = 1'b0;
    for (int k = 1; k <= 8; k++) step();
    n_cmp++; if (cnt_q !== 8'd7) begin n_err++; $display("FAIL mid_pre got %0d want 7", cnt_q); end
    clr_n = 1'b0;
    #1;
    n_cmp++; if ({cnt_en, cnt_clr_n, busy} !== 3'b000) begin n_err++; $display("FAIL mid_rst got %b want 000", {cnt_en, cnt_clr_n, busy}); end
    n_cmp++; if (cnt_q !== 8'd0) begin n_err++; $display("FAIL mid_cnt got %0d want 0", cnt_q); end
    step(); step();
    clr_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      n_cmp++; if ({cnt_clr_n, cnt_en, busy} !== 3'b100) begin n_err++; $display("FAIL mid_idle k=%0d got %b want 100", k, {cnt_clr_n, cnt_en, busy}); end
    end
    n_cmp++; if (cnt_q !== 8'd0) begin n_err++; $display("FAIL mid_cnt_after got %0d want 0", cnt_q); end
  endtask

  // ---------------- sequence + final report ----------------
  initial begin
    test_reset();
    test_one_shot();
    test_periodic();
    test_hold_resume();
    test_err();
    test_stop_at_match();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
